// File: rtl/fir_ntap_tree.sv
// N-tap moving-sum FIR: sample delay line into a balanced adder tree.
// Define FIR_AVG_EN to add a rounded moving-average output (avg).
module fir_ntap_tree #(
  parameter int W    = 16,
  parameter int TAPS = 4,
  parameter int PIPE = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [W-1:0]                a,
  output logic                        out_valid,
`ifdef FIR_AVG_EN
  output logic [W-1:0]                avg,
`endif
  output logic [W+$clog2(TAPS)-1:0]   s
);

  localparam int D   = $clog2(TAPS);
  localparam int SW  = W + D;
  localparam int LAT = 1 + PIPE * (D - 1);
  localparam int CW  = $clog2(TAPS + 1);

`ifdef FIR_AVG_EN
  if ((1 << D) != TAPS) begin : g_taps_chk
    $error("fir_ntap_tree: avg output needs power-of-two TAPS");
  end
`endif

  logic [W-1:0]   tap_q [TAPS];
  logic [W-1:0]   tap_d [TAPS];
  logic [SW-1:0]  lvl_q [D+1][TAPS+1];
  logic [SW-1:0]  lvl_d [D+1][TAPS+1];
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic           out_valid_q, out_valid_d;
  logic [SW-1:0]  s_q, s_d;
  logic [SW-1:0]  tree_sum;
  logic           full;
`ifdef FIR_AVG_EN
  logic [W-1:0]   avg_q, avg_d;
  logic [SW-1:0]  rnd;
`endif

  always_comb begin : p_line
    tap_d = tap_q;
    cnt_d = cnt_q;
    full  = cnt_q >= CW'(TAPS - 1);
    if (in_valid) begin
      tap_d[0] = a;
      for (int i = 1; i < TAPS; i++) tap_d[i] = tap_q[i-1];
      if (cnt_q < CW'(TAPS)) cnt_d = cnt_q + 1'b1;
    end
    if (clear) begin
      for (int i = 0; i < TAPS; i++) tap_d[i] = '0;
      cnt_d = '0;
    end
  end

  // Level l holds ceil(n/2) nodes; an odd leftover passes straight up.
  always_comb begin : p_tree
    logic [SW-1:0] cur [TAPS+1];
    logic [SW-1:0] nxt [TAPS+1];
    int n;
    for (int l = 0; l <= D; l++)
      for (int j = 0; j <= TAPS; j++) lvl_d[l][j] = '0;
    for (int j = 0; j <= TAPS; j++) cur[j] = '0;
    for (int j = 0; j < TAPS; j++)
      cur[j] = {{D{tap_q[j][W-1]}}, tap_q[j]};
    n = TAPS;
    for (int l = 1; l <= D; l++) begin
      for (int j = 0; j <= TAPS; j++) nxt[j] = '0;
      for (int j = 0; j < (TAPS + 1) / 2; j++) begin
        if (2 * j + 1 < n)  nxt[j] = cur[2*j] + cur[2*j+1];
        else if (2 * j < n) nxt[j] = cur[2*j];
      end
      if (PIPE != 0 && l < D) begin
        for (int j = 0; j <= TAPS; j++) begin
          lvl_d[l][j] = clear ? '0 : nxt[j];
          cur[j]      = lvl_q[l][j];
        end
      end else begin
        for (int j = 0; j <= TAPS; j++) cur[j] = nxt[j];
      end
      n = (n + 1) / 2;
    end
    tree_sum = cur[0];
  end

  always_comb begin : p_out
    vld_d[0] = in_valid & full;
    for (int i = 1; i < LAT; i++) vld_d[i] = vld_q[i-1];
    out_valid_d = vld_q[LAT-1];
    s_d = vld_q[LAT-1] ? tree_sum : s_q;
`ifdef FIR_AVG_EN
    rnd   = tree_sum + (SW'(1) << (D - 1));
    avg_d = vld_q[LAT-1] ? rnd[SW-1:D] : avg_q;
`endif
    if (clear) begin
      vld_d       = '0;
      out_valid_d = 1'b0;
      s_d         = '0;
`ifdef FIR_AVG_EN
      avg_d       = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) tap_q[i] <= '0;
      for (int l = 0; l <= D; l++)
        for (int j = 0; j <= TAPS; j++) lvl_q[l][j] <= '0;
      cnt_q       <= '0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
`ifdef FIR_AVG_EN
      avg_q       <= '0;
`endif
    end else begin
      tap_q       <= tap_d;
      lvl_q       <= lvl_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
`ifdef FIR_AVG_EN
      avg_q       <= avg_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
`ifdef FIR_AVG_EN
  assign avg       = avg_q;
`endif

endmodule

// File: tb/tb_fir_ntap_tree.sv
// Bench for fir_ntap_tree: two configurations checked every cycle
// against a queue-based window-sum model plus literal expectations.
module tb_fir_ntap_tree;

  localparam int W  = 16;
  localparam int TA = 4;
  localparam int LA = 2;
`ifdef FIR_AVG_EN
  localparam int TB = 8;
`else
  localparam int TB = 5;
`endif
  localparam int LB = 1;
  localparam int DA = 2;
  localparam int DB = $clog2(TB);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic ov_a, ov_b;
  logic [W+DA-1:0] s_a;
  logic [W+DB-1:0] s_b;
`ifdef FIR_AVG_EN
  logic [W-1:0] avg_a, avg_b;
`endif

  always #5 clk = ~clk;

  fir_ntap_tree #(.W(W), .TAPS(TA), .PIPE(1)) u_a (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .a(a), .out_valid(ov_a),
`ifdef FIR_AVG_EN
    .avg(avg_a),
`endif
    .s(s_a)
  );

  fir_ntap_tree #(.W(W), .TAPS(TB), .PIPE(0)) u_b (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .a(a), .out_valid(ov_b),
`ifdef FIR_AVG_EN
    .avg(avg_b),
`endif
    .s(s_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses_a = 0;
  bit run = 0;

  task automatic check(string nm, integer act, integer exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: accepted-sample history, results scheduled LAT edges later.
  typedef struct { int due; int sum; int av; } pend_t;
  int hist[$];
  pend_t pq_a[$];
  pend_t pq_b[$];
  int cyc = 0;
  int e_sa = 0, e_sb = 0, e_aa = 0, e_ab = 0;
  bit e_va = 0, e_vb = 0;

  function automatic int wsum(int n);
    int t = 0;
    for (int i = 0; i < n; i++) t += hist[hist.size() - 1 - i];
    return t;
  endfunction

  function automatic int rnd(int v, int d);
    return (v + (1 << (d - 1))) >>> d;
  endfunction

  task automatic flush();
    hist.delete();
    pq_a.delete();
    pq_b.delete();
    e_sa = 0; e_sb = 0; e_aa = 0; e_ab = 0;
    e_va = 0; e_vb = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) flush();
    else begin
      int t;
      cyc++;
      e_va = 0;
      e_vb = 0;
      if (pq_a.size() > 0 && pq_a[0].due == cyc) begin
        e_va = 1; e_sa = pq_a[0].sum; e_aa = pq_a[0].av;
        pq_a.delete(0);
      end
      if (pq_b.size() > 0 && pq_b[0].due == cyc) begin
        e_vb = 1; e_sb = pq_b[0].sum; e_ab = pq_b[0].av;
        pq_b.delete(0);
      end
      if (clear) flush();
      else if (in_valid) begin
        hist.push_back(int'($signed(a)));
        if (hist.size() > TB) hist.delete(0);
        if (hist.size() >= TA) begin
          t = wsum(TA);
          pq_a.push_back('{cyc + LA, t, rnd(t, DA)});
        end
        if (hist.size() >= TB) begin
          t = wsum(TB);
          pq_b.push_back('{cyc + LB, t, rnd(t, DB)});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("cyc_ov_a", ov_a, e_va);
      check("cyc_s_a", $signed(s_a), e_sa);
      check("cyc_ov_b", ov_b, e_vb);
      check("cyc_s_b", $signed(s_b), e_sb);
`ifdef FIR_AVG_EN
      check("cyc_avg_a", $signed(avg_a), e_aa);
      check("cyc_avg_b", $signed(avg_b), e_ab);
`endif
      if (ov_a) pulses_a++;
    end
  end

  task automatic put(bit v, int x);
    in_valid = v;
    a = W'(x);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    put(0, 0);
    clear = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    run = 1;
    check("rst_ov_a", ov_a, 0);
    check("rst_s_a", $signed(s_a), 0);
    check("rst_s_b", $signed(s_b), 0);
    reset = 1'b1;
    put(0, 0);

    put(1, 1); put(1, 2); put(1, 3); put(1, 4);
    check("s1_early_ov_a", ov_a, 0);
    put(1, 5);
    check("s1_lat_ov_a", ov_a, 0);
    put(0, 0);
    check("s1_first_ov_a", ov_a, 1);
    check("s1_first_s_a", $signed(s_a), 10);
`ifndef FIR_AVG_EN
    check("s1_first_ov_b", ov_b, 1);
    check("s1_first_s_b", $signed(s_b), 15);
`endif
    put(0, 0);
    check("s1_next_s_a", $signed(s_a), 14);

    for (int i = 0; i < 4; i++) put(1, -32768);
    put(0, 0); put(0, 0);
    check("s2_min_s_a", $signed(s_a), -131072);
`ifndef FIR_AVG_EN
    check("s2_min_s_b", $signed(s_b), -131067);
`endif
    for (int i = 0; i < 4; i++) put(1, 32767);
    put(0, 0); put(0, 0);
    check("s2_max_s_a", $signed(s_a), 131068);
`ifndef FIR_AVG_EN
    check("s2_max_s_b", $signed(s_b), 98300);
`endif

    do_clear();
    pulses_a = 0;
    put(1, 10); put(0, 0); put(1, 20); put(0, 0);
    put(1, 30); put(0, 0); put(1, 40);
    for (int i = 0; i < 4; i++) put(0, 0);
    check("s3_pulses_a", pulses_a, 1);
    check("s3_hold_s_a", $signed(s_a), 100);
    check("s3_idle_ov_b", ov_b, 0);

    pulses_a = 0;
    put(1, 50); put(1, 60);
    clear = 1'b1;
    put(1, 99);
    clear = 1'b0;
    check("s4_clr_s_a", $signed(s_a), 0);
    check("s4_clr_ov_a", ov_a, 0);
    put(1, 7); put(1, 8); put(1, 9); put(1, 10); put(0, 0);
    check("s4_pulses_a", pulses_a, 0);
    put(0, 0);
    check("s4_full_ov_a", ov_a, 1);
    check("s4_full_s_a", $signed(s_a), 34);

    put(1, 1); put(1, 2); put(1, 3);
    check("s5_pre_ov_a", ov_a, 1);
    check("s5_pre_s_a", $signed(s_a), 28);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("s5_arst_s_a", $signed(s_a), 0);
    check("s5_arst_ov_a", ov_a, 0);
    check("s5_arst_s_b", $signed(s_b), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    put(1, 1); put(1, 2); put(1, 3); put(1, 4); put(1, 5);
`ifndef FIR_AVG_EN
    check("s5_odd_ov_b", ov_b, 0);
`endif
    put(0, 0);
    check("s5_again_s_a", $signed(s_a), 10);
`ifndef FIR_AVG_EN
    check("s5_odd_ov_b1", ov_b, 1);
    check("s5_odd_s_b", $signed(s_b), 15);
`endif

`ifdef FIR_AVG_EN
    do_clear();
    put(1, 1); put(1, 2); put(1, 2); put(1, 2);
    put(0, 0); put(0, 0);
    check("s6_pos_s_a", $signed(s_a), 7);
    check("s6_pos_avg_a", $signed(avg_a), 2);
    put(1, -1); put(1, -2); put(1, -2); put(1, -2);
    put(0, 0); put(0, 0);
    check("s6_neg_s_a", $signed(s_a), -7);
    check("s6_neg_avg_a", $signed(avg_a), -2);
`endif

    put(0, 0); put(0, 0);
    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_ntap_tree.md
Name: fir_ntap_tree

Overview:
Parametrised N-tap moving-sum FIR: delay line of TAPS signed samples feeding a balanced adder tree, with optional register ranks between tree levels.
- Adds a sample-enable/valid handshake, a priming counter so output is flagged only for full windows, and a synchronous clear.
- Drop-in successor to the fixed 4-tap ripple/sum datapath blocks in the FIR lab set.

Parameters:
W, 16, input sample width (signed, two's complement), W>=2
TAPS, 4, number of taps (window length), TAPS>=2, any integer
PIPE, 1, 1 = register between every adder-tree level; 0 = single combinational tree into output register

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = reset asserted)
clear  input  1  synchronous flush of delay line, prime counter and in-flight valids
in_valid  input  1  sample enable; a is accepted on a rising edge where in_valid=1
a  input  W  signed input sample
out_valid  output  1  s holds a full-window sum produced this cycle (one-cycle pulse per result)
s  output  W+clog2(TAPS)  signed sum of last TAPS accepted samples

Behaviour:
- D = clog2(TAPS) tree levels; SW = W+clog2(TAPS); all operands sign-extended to SW, so overflow is impossible.
- Reset (reset=0, async, no clock needed): taps, tree registers, valid pipe, prime counter, s, out_valid all 0. Deassertion takes effect at the next edge.
- Delay line: on an edge with in_valid=1, tap[0]<=a and tap[i]<=tap[i-1]. With in_valid=0, taps hold; no backpressure.
- Tree:
  - Pairs summed per level; an odd leftover passes through (registered when PIPE=1) with no extra latency penalty.
  - PIPE=1 adds D-1 register ranks; the last level feeds the s register.
- Latency, counted from the accepting edge k: s/out_valid update after edge k+LAT, with LAT = 1 + PIPE*(D-1). Example: TAPS=4, PIPE=1 gives LAT=2; PIPE=0 gives LAT=1.
- Valid pipe: a token equal to (in_valid & window_full) is launched at edge k and shifts every cycle, LAT stages deep. out_valid is the final stage.
  - window_full: the prime counter, including the current sample, reaches TAPS.
- Prime counter: increments per accepted sample and saturates at TAPS.
  - First out_valid occurs for the TAPS-th accepted sample after reset/clear; afterwards one pulse per accepted sample.
- s register: updates only when the final-stage token is 1; otherwise holds its last value.
- Clear (sync), on an edge with clear=1:
  - zeroes taps, prime counter, tree registers, valid pipe, s, out_valid;
  - clear=1 with in_valid=1: clear wins, sample dropped.
- Reset mid-operation: outputs go to 0 immediately; all in-flight results are discarded.
- Back-to-back in_valid: full throughput, one result per cycle.

Optional Feature:
FIR_AVG_EN
- Defined: adds output port avg (W bits, signed), a moving average registered alongside s with identical latency and enable.
  - avg = (tree_sum + 2^(D-1)) >>> D, i.e. arithmetic shift with round-half-up.
  - TAPS must be a power of two; elaboration fails otherwise.
  - Reset and clear set avg to 0.
- Undefined: no avg port, no rounding logic; TAPS unrestricted.

Test Plan:
1. W=16, TAPS=4, PIPE=1; reset low then high; a=1,2,3,4,5 on consecutive cycles with in_valid=1 -> out_valid first high 2 cycles after sample 4 with s=10, then next cycle s=14; no out_valid earlier.
2. Extremes: four samples of -32768 -> s=-131072 (18'h20000); then four of 32767 -> s=131068; no wrap.
3. Gapped input: samples 10,20,30,40 with in_valid=0 between each -> exactly one out_valid pulse, s=100; s holds 100 while idle.
4. Clear: after priming, assert clear together with in_valid (a=99) -> 99 dropped; out_valid 0 for in-flight cycles; next 3 accepted samples give no output; 4th gives its full-window sum.
5. Async reset: pull reset low between clock edges while out_valid=1 -> s=0 and out_valid=0 before the next edge; repeat scenario 1 with PIPE=0 and TAPS=5 (odd tree) -> first output after 1 cycle, s=15.
6. FIR_AVG_EN, TAPS=4: samples 1,2,2,2 -> s=7, avg=2; samples -1,-2,-2,-2 -> s=-7, avg=-2.
